char_stream_normalizer: RTL

//   Upstream feeder for the begin/end block checker. Accepts raw ASCII bytes over a

---
 rtl/char_stream_normalizer.sv | 82 ++++++++
 1 files changed

// File: rtl/char_stream_normalizer.sv
// Case-folding / whitespace-mapping byte FIFO feeding the begin/end block checker.
// Optional STREAM_WS_COLLAPSE_EN drops whitespace that follows whitespace (and leading whitespace).
module char_stream_normalizer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [7:0]    in_char,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_char,
    input  logic          out_ready,
    output logic [AW:0]   level
);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mapped;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        write_en;

    always_comb begin
        mapped = in_char;
        if (in_char >= 8'h41 && in_char <= 8'h5A)
            mapped = in_char + 8'h20;
        else if (in_char == 8'h09 || in_char == 8'h0A || in_char == 8'h0D)
            mapped = 8'h20;
    end

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = wr_ptr - rd_ptr;
    assign out_char  = mem[rd_ptr[AW-1:0]];

`ifdef STREAM_WS_COLLAPSE_EN
    logic last_ws;

    // The handshake still completes for a dropped space; only the write is suppressed.
    assign write_en = push && !(last_ws && mapped == 8'h20);

    always_ff @(posedge clk) begin
        if (reset || flush)
            last_ws <= 1'b1;
        else if (push)
            last_ws <= (mapped == 8'h20);
    end
`else
    assign write_en = push;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en && !reset && !flush)
            mem[wr_ptr[AW-1:0]] <= mapped;
    end
endmodule
